axi_master_rr_arbiter: RTL and testbench

- Next-generation master-side arbiter for the AXI4 interconnect.
- Generalises the fixed-priority master arbiter in four ways:
  - any master count, not only powers of two;
  - selectable fixed-priority or round-robin arbitration;
  - a write-order FIFO that decouples the AW and W channels, so several AW bursts can be accepted before their W data completes;
  - an AW stall output when that FIFO is full.
- Sits between the master-side muxes and the slave arbiter.
- B and R return paths are still steered by the master-index field of the returned ID.

---
 rtl/axi_master_rr_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_axi_master_rr_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_rr_arbiter.sv
// axi_master_rr_arbiter
//
// Master-side arbiter for the AXI4 interconnect. It picks which master drives
// the shared AW and AR channels and keeps the W channel in AW order through a
// small write-order FIFO. It also steers B and R responses back to their
// master, using the master-index field of the returned ID.
//
// Handshake rule on every bus channel used here: a transfer happens on a
// rising clk edge where VALID and READY are both high. Once VALID is raised
// with READY low, the granted master keeps the channel until that transfer
// completes. VALID and READY are sampled only; this block drives neither.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   MASTER_WR_ADDR_VALID      per-master AWVALID requests
//   MASTER_RD_ADDR_VALID      per-master ARVALID requests
//   BUS_WR_ADDR_VALID/READY   muxed AW handshake
//   BUS_WR_DATA_VALID/READY   muxed W handshake
//   BUS_WR_DATA_LAST          WLAST of the muxed W beat
//   BUS_WR_BACK_ID            BID (master index above the M_ID low bits)
//   BUS_RD_ADDR_VALID/READY   muxed AR handshake
//   BUS_RD_BACK_ID            RID (master index above the M_ID low bits)
//   wr_addr_master_sel        AW mux select
//   wr_addr_stall             AW mux must hold BUS_WR_ADDR_VALID low
//   wr_data_master_sel        W mux select
//   wr_data_sel_valid         W select meaningful; W mux gates WVALID when low
//   wr_fifo_count             number of AW bursts still awaiting WLAST
//   wr_resp_master_sel        B demux select
//   rd_addr_master_sel        AR mux select
//   rd_data_master_sel        R demux select
module axi_master_rr_arbiter #(
    parameter int M_NUM         = 4,
    parameter int M_WIDTH       = 2,
    parameter int M_ID          = 2,
    parameter int ARB_MODE      = 1,
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [M_NUM-1:0]                    MASTER_WR_ADDR_VALID,
    input  logic [M_NUM-1:0]                    MASTER_RD_ADDR_VALID,
    input  logic                                BUS_WR_ADDR_VALID,
    input  logic                                BUS_WR_ADDR_READY,
    input  logic                                BUS_WR_DATA_VALID,
    input  logic                                BUS_WR_DATA_READY,
    input  logic                                BUS_WR_DATA_LAST,
    input  logic [M_ID+M_WIDTH-1:0]             BUS_WR_BACK_ID,
    input  logic                                BUS_RD_ADDR_VALID,
    input  logic                                BUS_RD_ADDR_READY,
    input  logic [M_ID+M_WIDTH-1:0]             BUS_RD_BACK_ID,
    output logic [M_WIDTH-1:0]                  wr_addr_master_sel,
    output logic                                wr_addr_stall,
    output logic [M_WIDTH-1:0]                  wr_data_master_sel,
    output logic                                wr_data_sel_valid,
    output logic [$clog2(WR_FIFO_DEPTH):0]      wr_fifo_count,
    output logic [M_WIDTH-1:0]                  wr_resp_master_sel,
    output logic [M_WIDTH-1:0]                  rd_addr_master_sel,
    output logic [M_WIDTH-1:0]                  rd_data_master_sel
);

    localparam int FA = $clog2(WR_FIFO_DEPTH);
    localparam int CW = FA + 1;

    // Search order is ptr, ptr+1, ... wrapping at M_NUM (round-robin) or
    // 0, 1, ... (fixed). The loop walks the order backwards so that the last
    // hit, which is the one kept, is the first requester in search order.
    // With no requester the previous select is returned unchanged.
    function automatic logic [M_WIDTH-1:0] pick_master(
        input logic [M_NUM-1:0]   req,
        input logic [M_WIDTH-1:0] ptr,
        input logic [M_WIDTH-1:0] hold
    );
        logic [M_WIDTH-1:0] res;
        logic [M_NUM-1:0]   sh;
        int                 idx;
        res = hold;
        for (int i = M_NUM - 1; i >= 0; i--) begin
            if (ARB_MODE == 0) begin
                idx = i;
            end else begin
                idx = int'(ptr) + i;
                if (idx >= M_NUM) idx = idx - M_NUM;
            end
            sh = req >> idx;
            if (sh[0]) res = M_WIDTH'(idx);
        end
        return res;
    endfunction

    function automatic logic [M_WIDTH-1:0] next_ptr(input logic [M_WIDTH-1:0] sel);
        return (int'(sel) >= M_NUM - 1) ? '0 : sel + M_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // AW arbitration
    // ------------------------------------------------------------------
    logic               aw_lock;
    logic [M_WIDTH-1:0] aw_sel_q;
    logic [M_WIDTH-1:0] aw_ptr;
    logic               aw_hs;

    assign aw_hs              = BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY;
    assign wr_addr_master_sel = aw_lock ? aw_sel_q
                                        : pick_master(MASTER_WR_ADDR_VALID, aw_ptr, aw_sel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_lock  <= 1'b0;
            aw_sel_q <= '0;
            aw_ptr   <= '0;
        end else begin
            aw_sel_q <= wr_addr_master_sel;
            if (aw_hs) begin
                aw_lock <= 1'b0;
                aw_ptr  <= next_ptr(wr_addr_master_sel);
            end else if (BUS_WR_ADDR_VALID) begin
                aw_lock <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // AR arbitration (same rules, own lock and pointer)
    // ------------------------------------------------------------------
    logic               ar_lock;
    logic [M_WIDTH-1:0] ar_sel_q;
    logic [M_WIDTH-1:0] ar_ptr;
    logic               ar_hs;

    assign ar_hs              = BUS_RD_ADDR_VALID && BUS_RD_ADDR_READY;
    assign rd_addr_master_sel = ar_lock ? ar_sel_q
                                        : pick_master(MASTER_RD_ADDR_VALID, ar_ptr, ar_sel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_lock  <= 1'b0;
            ar_sel_q <= '0;
            ar_ptr   <= '0;
        end else begin
            ar_sel_q <= rd_addr_master_sel;
            if (ar_hs) begin
                ar_lock <= 1'b0;
                ar_ptr  <= next_ptr(rd_addr_master_sel);
            end else if (BUS_RD_ADDR_VALID) begin
                ar_lock <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-order FIFO
    // ------------------------------------------------------------------
    logic [M_WIDTH-1:0] fifo_mem [WR_FIFO_DEPTH];
    logic [FA-1:0]      wptr;
    logic [FA-1:0]      rptr;
    logic [CW-1:0]      cnt;
    logic               w_last_hs;
    logic               fifo_empty;
    logic               fifo_full;
    logic               bypass;
    logic               do_push;
    logic               do_pop;

    assign w_last_hs  = BUS_WR_DATA_VALID && BUS_WR_DATA_READY && BUS_WR_DATA_LAST;
    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == CW'(WR_FIFO_DEPTH));
    assign bypass     = fifo_empty && aw_hs;

    // A bypassed burst that also ends this cycle never enters storage.
    // A push that arrives while the FIFO is full is dropped.
    assign do_push = aw_hs && !fifo_full && !(bypass && w_last_hs);
    assign do_pop  = w_last_hs && !fifo_empty;

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wptr] <= wr_addr_master_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + FA'(1);
            if (do_pop)  rptr <= rptr + FA'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign wr_fifo_count      = cnt;
    assign wr_addr_stall      = fifo_full;
    assign wr_data_master_sel = bypass ? wr_addr_master_sel : fifo_mem[rptr];
    assign wr_data_sel_valid  = bypass || !fifo_empty;

    // ------------------------------------------------------------------
    // Response steering straight from the returned ID
    // ------------------------------------------------------------------
    assign wr_resp_master_sel = BUS_WR_BACK_ID[M_ID +: M_WIDTH];
    assign rd_data_master_sel = BUS_RD_BACK_ID[M_ID +: M_WIDTH];

    // The master's own ID bits are not needed for steering.
    logic unused_id_bits;
    assign unused_id_bits = ^{BUS_WR_BACK_ID[M_ID-1:0], BUS_RD_BACK_ID[M_ID-1:0]};

endmodule

// File: tb/tb_axi_master_rr_arbiter.sv
module tb_axi_master_rr_arbiter;

    localparam int M_NUM   = 4;
    localparam int M_WIDTH = 2;
    localparam int M_ID    = 2;
    localparam int DEPTH   = 4;
    localparam int IDW     = M_ID + M_WIDTH;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     aw_valid, ar_valid;
    logic           bus_aw_valid, bus_aw_ready;
    logic           w_valid, w_ready, w_last;
    logic           bus_ar_valid, bus_ar_ready;
    logic [IDW-1:0] b_id, r_id;

    logic [1:0]     aw_sel, w_sel, b_sel, ar_sel, r_sel;
    logic           aw_stall, w_sel_valid;
    logic [2:0]     w_cnt;

    logic [1:0]     fp_aw_sel, fp_unused_w_sel, fp_b_sel, fp_ar_sel, fp_r_sel;
    logic           fp_aw_stall, fp_w_sel_valid;
    logic [2:0]     fp_w_cnt;

    axi_master_rr_arbiter #(
        .M_NUM(M_NUM), .M_WIDTH(M_WIDTH), .M_ID(M_ID), .ARB_MODE(1), .WR_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .MASTER_WR_ADDR_VALID(aw_valid), .MASTER_RD_ADDR_VALID(ar_valid),
        .BUS_WR_ADDR_VALID(bus_aw_valid), .BUS_WR_ADDR_READY(bus_aw_ready),
        .BUS_WR_DATA_VALID(w_valid), .BUS_WR_DATA_READY(w_ready), .BUS_WR_DATA_LAST(w_last),
        .BUS_WR_BACK_ID(b_id),
        .BUS_RD_ADDR_VALID(bus_ar_valid), .BUS_RD_ADDR_READY(bus_ar_ready),
        .BUS_RD_BACK_ID(r_id),
        .wr_addr_master_sel(aw_sel), .wr_addr_stall(aw_stall),
        .wr_data_master_sel(w_sel), .wr_data_sel_valid(w_sel_valid),
        .wr_fifo_count(w_cnt), .wr_resp_master_sel(b_sel),
        .rd_addr_master_sel(ar_sel), .rd_data_master_sel(r_sel)
    );

    // Fixed-priority, three-master instance sharing the same bus signals.
    axi_master_rr_arbiter #(
        .M_NUM(3), .M_WIDTH(M_WIDTH), .M_ID(M_ID), .ARB_MODE(0), .WR_FIFO_DEPTH(DEPTH)
    ) dut_fp (
        .clk(clk), .rst(rst),
        .MASTER_WR_ADDR_VALID(aw_valid[2:0]), .MASTER_RD_ADDR_VALID(ar_valid[2:0]),
        .BUS_WR_ADDR_VALID(bus_aw_valid), .BUS_WR_ADDR_READY(bus_aw_ready),
        .BUS_WR_DATA_VALID(w_valid), .BUS_WR_DATA_READY(w_ready), .BUS_WR_DATA_LAST(w_last),
        .BUS_WR_BACK_ID(b_id),
        .BUS_RD_ADDR_VALID(bus_ar_valid), .BUS_RD_ADDR_READY(bus_ar_ready),
        .BUS_RD_BACK_ID(r_id),
        .wr_addr_master_sel(fp_aw_sel), .wr_addr_stall(fp_aw_stall),
        .wr_data_master_sel(fp_unused_w_sel), .wr_data_sel_valid(fp_w_sel_valid),
        .wr_fifo_count(fp_w_cnt), .wr_resp_master_sel(fp_b_sel),
        .rd_addr_master_sel(fp_ar_sel), .rd_data_master_sel(fp_r_sel)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    bit               m_aw_lock, m_ar_lock;
    int               m_aw_hold, m_ar_hold, m_aw_ptr, m_ar_ptr;
    int               m_fp_aw_hold, m_fp_ar_hold;
    logic [M_WIDTH-1:0] exp_q[$];   // bursts awaiting WLAST, oldest first

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner = requester closest to ptr going upward with wrap (round-robin),
    // or the lowest requester (fixed). Locked or idle keeps the old select.
    function automatic int ref_grant(input int n, input bit rr, input logic [3:0] req,
                                     input int ptr, input int hold, input bit lock);
        int best, best_d, d;
        if (lock) return hold;
        best   = -1;
        best_d = n + 1;
        for (int i = 0; i < n; i++) begin
            if (((req >> i) & 4'd1) != 4'd0) begin
                d = rr ? (i - ptr + n) % n : i;
                if (d < best_d) begin
                    best   = i;
                    best_d = d;
                end
            end
        end
        return (best < 0) ? hold : best;
    endfunction

    task automatic model_reset();
        m_aw_lock = 0; m_ar_lock = 0;
        m_aw_hold = 0; m_ar_hold = 0;
        m_aw_ptr  = 0; m_ar_ptr  = 0;
        m_fp_aw_hold = 0; m_fp_ar_hold = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_aw(input logic [3:0] req, input logic v, input logic r);
        aw_valid = req; bus_aw_valid = v; bus_aw_ready = r;
    endtask

    task automatic drive_w(input logic v, input logic r, input logic l);
        w_valid = v; w_ready = r; w_last = l;
    endtask

    task automatic drive_ar(input logic [3:0] req, input logic v, input logic r);
        ar_valid = req; bus_ar_valid = v; bus_ar_ready = r;
    endtask

    task automatic idle();
        drive_aw(4'b0, 1'b0, 1'b0);
        drive_w(1'b0, 1'b0, 1'b0);
        drive_ar(4'b0, 1'b0, 1'b0);
        b_id = '0;
        r_id = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: compare every output against the model shortly after the
    // inputs settle, then advance the model on the rising edge.
    task automatic step();
        int g, gf, ga, gaf, cnt;
        bit aw_hs, ar_hs, pop, byp, push_ok;
        #1;
        g   = ref_grant(4, 1'b1, aw_valid, m_aw_ptr, m_aw_hold, m_aw_lock);
        gf  = ref_grant(3, 1'b0, {1'b0, aw_valid[2:0]}, 0, m_fp_aw_hold, m_aw_lock);
        ga  = ref_grant(4, 1'b1, ar_valid, m_ar_ptr, m_ar_hold, m_ar_lock);
        gaf = ref_grant(3, 1'b0, {1'b0, ar_valid[2:0]}, 0, m_fp_ar_hold, m_ar_lock);
        cnt   = exp_q.size();
        aw_hs = bus_aw_valid && bus_aw_ready;
        ar_hs = bus_ar_valid && bus_ar_ready;
        pop   = w_valid && w_ready && w_last;
        byp   = (cnt == 0) && aw_hs;

        check_eq("aw_sel", aw_sel, g);
        check_eq("fp_aw_sel", fp_aw_sel, gf);
        check_eq("ar_sel", ar_sel, ga);
        check_eq("fp_ar_sel", fp_ar_sel, gaf);
        check_eq("w_cnt", w_cnt, cnt);
        check_eq("fp_w_cnt", fp_w_cnt, cnt);
        check_eq("aw_stall", aw_stall, cnt == DEPTH);
        check_eq("fp_aw_stall", fp_aw_stall, cnt == DEPTH);
        check_eq("w_sel_valid", w_sel_valid, byp || cnt > 0);
        check_eq("fp_w_sel_valid", fp_w_sel_valid, byp || cnt > 0);
        if (byp)          check_eq("w_sel_bypass", w_sel, g);
        else if (cnt > 0) check_eq("w_sel_head", w_sel, exp_q[0]);
        check_eq("b_sel", b_sel, b_id >> M_ID);
        check_eq("r_sel", r_sel, r_id >> M_ID);
        check_eq("fp_b_sel", fp_b_sel, b_id >> M_ID);
        check_eq("fp_r_sel", fp_r_sel, r_id >> M_ID);

        @(posedge clk);
        m_aw_hold = g;  m_fp_aw_hold = gf;
        m_ar_hold = ga; m_fp_ar_hold = gaf;
        if (aw_hs) begin
            m_aw_lock = 0;
            m_aw_ptr  = (g + 1) % M_NUM;
        end else if (bus_aw_valid) begin
            m_aw_lock = 1;
        end
        if (ar_hs) begin
            m_ar_lock = 0;
            m_ar_ptr  = (ga + 1) % M_NUM;
        end else if (bus_ar_valid) begin
            m_ar_lock = 1;
        end
        if (!(byp && pop)) begin
            push_ok = aw_hs && (cnt < DEPTH);
            if (pop && cnt > 0) void'(exp_q.pop_front());
            if (push_ok) exp_q.push_back(M_WIDTH'(g));
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int seq_rr[4];
    int seq_fill[4];

    initial begin
        seq_fill = '{1, 3, 0, 2};
        rst = 1'b1;
        idle();
        model_reset();
        #3;
        check_eq("rst_aw_sel", aw_sel, 0);
        check_eq("rst_ar_sel", ar_sel, 0);
        check_eq("rst_cnt", w_cnt, 0);
        check_eq("rst_stall", aw_stall, 0);
        check_eq("rst_w_valid", w_sel_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with AW always ready; fixed priority keeps master 0.
        apply_reset();
        drive_aw(4'b0111, 1'b1, 1'b1);
        drive_ar(4'b0111, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq("rr_aw_seq", aw_sel, k % 3);
            check_eq("rr_ar_seq", ar_sel, k % 3);
            check_eq("fp_aw_seq", fp_aw_sel, 0);
            step();
        end

        // Lock under backpressure.
        apply_reset();
        drive_aw(4'b0100, 1'b1, 1'b0);
        step();
        drive_aw(4'b0101, 1'b1, 1'b0);
        #1 check_eq("lock_hold1", aw_sel, 2);
        step();
        #1 check_eq("lock_hold2", aw_sel, 2);
        step();
        drive_aw(4'b0101, 1'b1, 1'b1);
        #1 check_eq("lock_hs", aw_sel, 2);
        step();
        drive_aw(4'b0001, 1'b1, 1'b0);
        #1 check_eq("lock_next", aw_sel, 0);
        step();

        // FIFO fill then drain in order.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive_aw(4'b0001 << seq_fill[k], 1'b1, 1'b1);
            step();
        end
        drive_aw(4'b0, 1'b0, 1'b0);
        #1;
        check_eq("fill_cnt", w_cnt, 4);
        check_eq("fill_stall", aw_stall, 1);
        step();
        drive_w(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("drain_sel", w_sel, seq_fill[k]);
            step();
            #1 check_eq("drain_stall", aw_stall, 0);
        end
        drive_w(1'b0, 1'b0, 1'b0);
        #1 check_eq("drain_cnt", w_cnt, 0);
        step();

        // Bypass: AW and single-beat WLAST together on an empty FIFO.
        apply_reset();
        drive_aw(4'b1000, 1'b1, 1'b1);
        drive_w(1'b1, 1'b1, 1'b1);
        #1;
        check_eq("byp_valid", w_sel_valid, 1);
        check_eq("byp_sel", w_sel, 3);
        step();
        idle();
        #1 check_eq("byp_cnt", w_cnt, 0);
        step();

        // Simultaneous push and pop with two queued bursts.
        apply_reset();
        drive_aw(4'b0010, 1'b1, 1'b1);
        step();
        drive_aw(4'b0100, 1'b1, 1'b1);
        step();
        drive_aw(4'b1000, 1'b1, 1'b1);
        drive_w(1'b1, 1'b1, 1'b1);
        #1 check_eq("pp_head0", w_sel, 1);
        step();
        idle();
        #1;
        check_eq("pp_cnt", w_cnt, 2);
        check_eq("pp_head1", w_sel, 2);
        step();

        // Asynchronous reset in mid-cycle with a locked AW and three bursts.
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive_aw(4'b0001 << k, 1'b1, 1'b1);
            step();
        end
        drive_aw(4'b0001, 1'b1, 1'b0);
        step();
        #1 check_eq("pre_rst_cnt", w_cnt, 3);
        aw_valid = 4'b0;
        #1 rst = 1'b1;
        #1;
        check_eq("arst_cnt", w_cnt, 0);
        check_eq("arst_stall", aw_stall, 0);
        check_eq("arst_valid", w_sel_valid, 0);
        check_eq("arst_aw_sel", aw_sel, 0);
        idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Response steering.
        r_id = 4'b1001;
        b_id = 4'b0111;
        #1;
        check_eq("resp_rd", r_sel, 2);
        check_eq("resp_wr", b_sel, 1);
        step();

        // Randomized traffic against the model.
        apply_reset();
        for (int k = 0; k < 800; k++) begin
            drive_aw(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            drive_ar(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            drive_w(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            b_id = IDW'($urandom_range(0, 15));
            r_id = IDW'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
